// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared widths, constants and types for the fetch stage.
package fetch_ctrl_pkg;
    localparam int WORD_WIDTH      = 32;
    localparam int IMEM_ADDR_WIDTH = 10;
    localparam logic [WORD_WIDTH-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {PC_PLUS4, PC_JAL_BXX, PC_JALR, PC_RESET} pc_sel_t;
    typedef enum logic [1:0] {FS_BOOT, FS_RUN, FS_FAULT} fetch_state_t;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] ir;
    } fetch_pkt_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: redirect inputs, imem port and decode handshake of the fetch stage.
interface fetch_ctrl_if #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [1:0]            pc_sel;
    logic [WORD_WIDTH-1:0] jal_bxx_tgt;
    logic [WORD_WIDTH-1:0] jalr_tgt;
    logic                  imem_en;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [WORD_WIDTH-1:0] imem_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_WIDTH-1:0] out_pc;
    logic [WORD_WIDTH-1:0] out_ir;
    logic                  fault;

    modport master (
        input  pc_sel, jal_bxx_tgt, jalr_tgt, imem_data, out_ready,
        output imem_en, imem_addr, out_valid, out_pc, out_ir, fault
    );
    modport slave (
        output pc_sel, jal_bxx_tgt, jalr_tgt, imem_data, out_ready,
        input  imem_en, imem_addr, out_valid, out_pc, out_ir, fault
    );
endinterface

// File: rtl/fetch_ctrl_buf.sv
// fetch_ctrl_buf: 2-entry skid FIFO of {pc, ir}; the head is a register so out_pc/out_ir are glitch-free.
module fetch_ctrl_buf
    import fetch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_flush,
    input  fetch_pkt_t i_pkt,
    output logic [1:0] o_count,
    output fetch_pkt_t o_head
);
    fetch_pkt_t r_head, r_tail;
    logic [1:0] r_count, w_idx;

    // slot the incoming packet lands in once this cycle's pop has shifted the queue
    assign w_idx   = r_count - {1'b0, i_pop};
    assign o_count = r_count;
    assign o_head  = r_head;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_count <= 2'd0;
            r_head  <= '{pc: '0, ir: NOP};
            r_tail  <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
            if (i_push && w_idx == 2'd0) r_head <= i_pkt;
            else if (i_pop) r_head <= r_tail;
            if (i_push && w_idx == 2'd1) r_tail <= i_pkt;
        end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer; owns the PC, drives a 1-cycle imem,
// applies redirects and hands {pc, ir} to decode through a skid buffer.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH = fetch_ctrl_pkg::WORD_WIDTH,
    parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter logic [WORD_WIDTH-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          reset,
    fetch_ctrl_if.master bus
);
    fetch_state_t r_state, w_state_n;
    fetch_pkt_t w_pkt, w_head;
    logic [WORD_WIDTH-1:0] r_fetch_pc, r_iss_pc, w_tgt, w_issue_pc;
    logic [2:0] w_credit;
    logic [1:0] w_count;
    logic r_inflight, w_run, w_pop, w_redirect, w_aligned, w_issue, w_push, w_flush;

    assign w_run      = r_state == FS_RUN;
    assign w_pop      = bus.out_valid && bus.out_ready;
    assign w_redirect = w_run && bus.pc_sel != PC_PLUS4;
    assign w_tgt      = bus.pc_sel == PC_JAL_BXX ? bus.jal_bxx_tgt
                      : bus.pc_sel == PC_JALR    ? bus.jalr_tgt & ~WORD_WIDTH'(1)
                      : RESET_PC;
    assign w_aligned  = w_tgt[1:0] == 2'b00;
    // occupied + reserved slots after this cycle's pop; issue only while one is free
    assign w_credit   = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_issue    = w_run && (w_redirect ? w_aligned : w_credit < 3'd2);
    assign w_issue_pc = w_redirect ? w_tgt : r_fetch_pc;
    assign w_push     = w_run && r_inflight && !w_redirect;
    assign w_flush    = w_redirect || r_state == FS_FAULT;
    assign w_pkt      = '{pc: r_iss_pc, ir: bus.imem_data};

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= FS_BOOT;
        else r_state <= w_state_n;

    always_comb
        w_state_n = r_state == FS_BOOT ? FS_RUN
                  : (w_redirect && !w_aligned) ? FS_FAULT
                  : r_state;

    always_comb begin
        bus.imem_en   = w_issue;
        bus.imem_addr = w_issue_pc[ADDR_WIDTH+1:2];
        bus.out_valid = w_count != 2'd0;
        bus.out_pc    = w_head.pc;
        bus.out_ir    = w_head.ir;
        bus.fault     = r_state == FS_FAULT;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_iss_pc   <= RESET_PC;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_pc <= w_issue_pc + WORD_WIDTH'(4);
                r_iss_pc   <= w_issue_pc;
            end
        end

    fetch_ctrl_buf u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_pkt   (w_pkt),
        .o_count (w_count),
        .o_head  (w_head)
    );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus with a queue-based reference model checked every cycle.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_ctrl_if bus ();
    fetch_ctrl_if bus2 ();

    fetch_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ir_of(input logic [31:0] pc);
        return {20'b0, pc[11:2], 2'b00};
    endfunction

    // imem stand-ins: each word holds its own byte address
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_data <= {20'b0, bus.imem_addr, 2'b00};
        if (bus2.imem_en) bus2.imem_data <= {20'b0, bus2.imem_addr, 2'b00};
    end

    int m_state;
    logic [31:0] m_fpc, m_ipc;
    bit m_inf;
    logic [31:0] m_q[$];
    logic [31:0] acc[$];
    logic [31:0] acc2[$];
    int cyc, first_en, first_val;

    function automatic logic [31:0] acc_at(input int i);
        return (i < acc.size()) ? acc[i] : 32'hDEAD_BEEF;
    endfunction

    always @(negedge clk) begin : cmp
        logic [31:0] tgt, ipc;
        logic pop, red, en, vld;
        if (reset) begin
            chk("rst_imem_en", {31'b0, bus.imem_en}, 0);
            chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
            chk("rst_fault", {31'b0, bus.fault}, 0);
            m_state = 0; m_fpc = 0; m_ipc = 0; m_inf = 0; m_q.delete();
            cyc = 0;
        end else begin
            cyc++;
            if (first_en == 0 && bus.imem_en) first_en = cyc;
            if (first_val == 0 && bus.out_valid) first_val = cyc;
            vld = m_q.size() != 0;
            chk("out_valid", {31'b0, bus.out_valid}, {31'b0, vld});
            if (vld) begin
                chk("out_pc", bus.out_pc, m_q[0]);
                chk("out_ir", bus.out_ir, ir_of(m_q[0]));
            end
            chk("fault", {31'b0, bus.fault}, {31'b0, m_state == 2});
            chk("buf_count", {30'b0, dut.u_buf.r_count}, m_q.size());
            pop = vld && bus.out_ready;
            red = m_state == 1 && bus.pc_sel != 2'b00;
            tgt = bus.pc_sel == 2'b01 ? bus.jal_bxx_tgt
                : bus.pc_sel == 2'b10 ? (bus.jalr_tgt & 32'hFFFF_FFFE) : 32'h0;
            en = m_state == 1 && (red ? tgt[1:0] == 2'b00
                                      : (m_q.size() + int'(m_inf) - int'(pop)) < 2);
            ipc = red ? tgt : m_fpc;
            chk("imem_en", {31'b0, bus.imem_en}, {31'b0, en});
            if (en) chk("imem_addr", {22'b0, bus.imem_addr}, {22'b0, ipc[11:2]});
            if (pop) acc.push_back(bus.out_pc);
            if (m_state == 0) m_state = 1;
            else if (m_state == 1) begin
                if (pop) void'(m_q.pop_front());
                if (red) begin
                    m_q.delete();
                    if (tgt[1:0] == 2'b00) begin
                        m_inf = 1; m_ipc = tgt; m_fpc = tgt + 4;
                    end else begin
                        m_state = 2; m_inf = 0;
                    end
                end else begin
                    if (m_inf) m_q.push_back(m_ipc);
                    m_inf = en;
                    if (en) begin m_ipc = m_fpc; m_fpc = m_fpc + 4; end
                end
            end
        end
        if (!reset && bus2.out_valid && acc2.size() < 4) acc2.push_back(bus2.out_pc);
    end

    initial begin : stim
        int n;
        bit ok;
        first_en = 0; first_val = 0;
        bus.pc_sel = 2'b00; bus.jal_bxx_tgt = '0; bus.jalr_tgt = '0; bus.out_ready = 1'b1;
        bus2.pc_sel = 2'b00; bus2.jal_bxx_tgt = '0; bus2.jalr_tgt = '0; bus2.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_pc", bus.out_pc, 32'h0);
        chk("rst_out_ir", bus.out_ir, 32'h0000_0013);
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("first_issue_cycle", first_en, 2);
        chk("first_valid_cycle", first_val, 4);
        bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("stall_imem_en", {31'b0, bus.imem_en}, 0);
        chk("stall_valid", {31'b0, bus.out_valid}, 1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("acc_size", acc.size(), 11);
        ok = 1;
        for (int i = 0; i < acc.size(); i++) if (acc[i] != 32'(4 * i)) ok = 0;
        chk("seq_no_gap_dup", {31'b0, ok}, 1);
        chk("resume_pc", acc_at(5), 32'h14);
        bus.pc_sel = 2'b01; bus.jal_bxx_tgt = 32'h100;
        @(negedge clk);
        chk("jal_imem_en", {31'b0, bus.imem_en}, 1);
        chk("jal_imem_addr", {22'b0, bus.imem_addr}, 32'h40);
        @(posedge clk);
        #1;
        bus.pc_sel = 2'b00;
        n = acc.size();
        repeat (4) @(posedge clk);
        #1;
        chk("jal_first_pc", acc_at(n), 32'h100);
        chk("jal_second_pc", acc_at(n + 1), 32'h104);
        bus.pc_sel = 2'b10; bus.jalr_tgt = 32'h201;
        @(negedge clk);
        chk("jalr_imem_addr", {22'b0, bus.imem_addr}, 32'h80);
        @(posedge clk);
        #1;
        bus.pc_sel = 2'b00;
        n = acc.size();
        repeat (4) @(posedge clk);
        #1;
        chk("jalr_first_pc", acc_at(n), 32'h200);
        chk("jalr_no_fault", {31'b0, bus.fault}, 0);
        bus.pc_sel = 2'b10; bus.jalr_tgt = 32'h202;
        @(negedge clk);
        chk("mis_no_issue", {31'b0, bus.imem_en}, 0);
        @(posedge clk);
        #1;
        bus.pc_sel = 2'b01; bus.jal_bxx_tgt = 32'h100;
        @(negedge clk);
        chk("mis_fault", {31'b0, bus.fault}, 1);
        chk("mis_valid", {31'b0, bus.out_valid}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("fault_sticky", {31'b0, bus.fault}, 1);
        chk("fault_imem_en", {31'b0, bus.imem_en}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.pc_sel = 2'b00;
        @(negedge clk);
        chk("reset_clears_fault", {31'b0, bus.fault}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        n = acc.size();
        repeat (6) @(posedge clk);
        #1;
        chk("restart_pc0", acc_at(n), 32'h0);
        chk("restart_pc1", acc_at(n + 1), 32'h4);
        chk("wrap_n", acc2.size(), 4);
        chk("wrap_0", acc2.size() > 0 ? acc2[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
        chk("wrap_1", acc2.size() > 1 ? acc2[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        chk("wrap_2", acc2.size() > 2 ? acc2[2] : 32'hDEAD_BEEF, 32'h0000_0000);
        chk("wrap_3", acc2.size() > 3 ? acc2[3] : 32'hDEAD_BEEF, 32'h0000_0004);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
